// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception control: stall/bubble generation, RUN/DRAIN/HALTED
// sequencing and free-running performance counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [1:0]       cpu_state,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] R_NONE   = 4'hF;

  state_t state, state_nxt;
  logic   load_use, ret_haz, mispred, m_exc, w_exc, active;

  assign load_use = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != R_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_haz  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispred  = (E_icode == I_JXX) && !e_cnd;
  assign m_exc    = (m_stat != STAT_AOK);
  assign w_exc    = (W_stat != STAT_AOK);
  assign active   = (state != HALTED);

  // Reported state reads RUN while reset is held so halted drops immediately.
  assign cpu_state = reset ? RUN : state;
  assign halted    = (cpu_state == HALTED);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    case (state)
      RUN: begin
        if (w_exc)      state_nxt = HALTED;
        else if (m_exc) state_nxt = DRAIN;
      end
      DRAIN:   if (w_exc) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
    if (reset) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state == HALTED) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      // load_use wins over ret_haz: the stalled D stage must not be bubbled.
      F_stall  = load_use | ret_haz;
      D_stall  = load_use;
      D_bubble = mispred | (ret_haz & !load_use);
      E_bubble = mispred | load_use;
      M_bubble = m_exc | w_exc;
      W_stall  = w_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt     <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
      ret_cnt     <= '0;
      retire_cnt  <= '0;
    end else if (active) begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (load_use | ret_haz)                          stall_cnt   <= stall_cnt + CNT_W'(1);
      if (mispred)                                     mispred_cnt <= mispred_cnt + CNT_W'(1);
      if (M_icode == I_RET)                            ret_cnt     <= ret_cnt + CNT_W'(1);
      if ((W_stat == STAT_AOK) && (W_icode != I_NOP))  retire_cnt  <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (CNT_W=4 so counter wrap is reachable).
module tb_pipe_ctrl;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM;
  logic          e_cnd;
  logic [2:0]    m_stat, W_stat;
  logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [1:0]    cpu_state;
  logic [CW-1:0] cyc_cnt, stall_cnt, mispred_cnt, ret_cnt, retire_cnt;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .cpu_state(cpu_state), .halted(halted),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt),
    .ret_cnt(ret_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] di, ei, mi, wi, sa, sb, edm;
    logic       cnd;
    logic [2:0] ms, ws;
  } stim_t;

  typedef struct {
    logic       fs, ds, db, eb, mb, wst, hl;
    logic [1:0] st;
    int         cyc, stl, mis, ret, rtr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  int m_st = 0;
  int m_cyc = 0, m_stl = 0, m_mis = 0, m_ret = 0, m_rtr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.di = 4'h6; s.ei = 4'h6; s.mi = 4'h6; s.wi = 4'h6;
    s.sa = 4'hF; s.sb = 4'hF; s.edm = 4'hF; s.cnd = 1'b1; s.ms = 3'd1; s.ws = 3'd1;
    return s;
  endfunction

  // One clock: drive, predict, compare mid-cycle, then advance the model.
  task automatic run(input stim_t s);
    exp_t e;
    bit   lu, rh, mp, mx, wx;
    reset = s.rst; D_icode = s.di; E_icode = s.ei; M_icode = s.mi; W_icode = s.wi;
    d_srcA = s.sa; d_srcB = s.sb; E_dstM = s.edm; e_cnd = s.cnd; m_stat = s.ms; W_stat = s.ws;
    lu = (s.ei == 4'h5 || s.ei == 4'hB) && s.edm != 4'hF && (s.edm == s.sa || s.edm == s.sb);
    rh = (s.di == 4'h9) || (s.ei == 4'h9) || (s.mi == 4'h9);
    mp = (s.ei == 4'h7) && !s.cnd;
    mx = (s.ms != 3'd1);
    wx = (s.ws != 3'd1);
    e.cyc = m_cyc; e.stl = m_stl; e.mis = m_mis; e.ret = m_ret; e.rtr = m_rtr;
    if (s.rst) begin
      e.fs = 0; e.ds = 0; e.db = 1; e.eb = 1; e.mb = 1; e.wst = 0; e.st = 2'd0; e.hl = 0;
    end else if (m_st == 2) begin
      e.fs = 1; e.ds = 1; e.db = 0; e.eb = 0; e.mb = 0; e.wst = 1; e.st = 2'd2; e.hl = 1;
    end else begin
      e.fs = lu | rh; e.ds = lu; e.db = mp | (rh & !lu); e.eb = mp | lu;
      e.mb = mx | wx; e.wst = wx; e.st = 2'(m_st); e.hl = 0;
    end
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk("F_stall", 32'(F_stall), 32'(e.fs));
    chk("D_stall", 32'(D_stall), 32'(e.ds));
    chk("D_bubble", 32'(D_bubble), 32'(e.db));
    chk("E_bubble", 32'(E_bubble), 32'(e.eb));
    chk("M_bubble", 32'(M_bubble), 32'(e.mb));
    chk("W_stall", 32'(W_stall), 32'(e.wst));
    chk("cpu_state", 32'(cpu_state), 32'(e.st));
    chk("halted", 32'(halted), 32'(e.hl));
    chk("cyc_cnt", 32'(cyc_cnt), 32'(e.cyc));
    chk("stall_cnt", 32'(stall_cnt), 32'(e.stl));
    chk("mispred_cnt", 32'(mispred_cnt), 32'(e.mis));
    chk("ret_cnt", 32'(ret_cnt), 32'(e.ret));
    chk("retire_cnt", 32'(retire_cnt), 32'(e.rtr));
    @(posedge clk);
    if (s.rst) begin
      m_st = 0; m_cyc = 0; m_stl = 0; m_mis = 0; m_ret = 0; m_rtr = 0;
    end else if (m_st != 2) begin
      m_cyc = (m_cyc + 1) % 16;
      if (lu | rh) m_stl = (m_stl + 1) % 16;
      if (mp) m_mis = (m_mis + 1) % 16;
      if (s.mi == 4'h9) m_ret = (m_ret + 1) % 16;
      if (s.ws == 3'd1 && s.wi != 4'h1) m_rtr = (m_rtr + 1) % 16;
      if (wx) m_st = 2;
      else if (mx && m_st == 0) m_st = 1;
    end
    #1;
  endtask

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    reset = 1'b1; D_icode = 0; E_icode = 0; M_icode = 0; W_icode = 0;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1; m_stat = 1; W_stat = 1;
    @(posedge clk); #1;
    run(s); run(s);
    run(idle());
    s = idle(); s.wi = 4'h1; run(s);                       // nop does not retire
    // load-use via srcA (mrmovq) and srcB (popq)
    s = idle(); s.ei = 4'h5; s.edm = 4'h3; s.sa = 4'h3; run(s);
    s = idle(); s.ei = 4'hB; s.edm = 4'h2; s.sb = 4'h2; run(s);
    s = idle(); s.ei = 4'h5; s.edm = 4'hF; run(s);         // none dst: no hazard
    // ret walking D -> E -> M
    s = idle(); s.di = 4'h9; run(s);
    s = idle(); s.ei = 4'h9; run(s);
    s = idle(); s.mi = 4'h9; run(s);
    // mispredict and correctly-taken jump
    s = idle(); s.ei = 4'h7; s.cnd = 1'b0; run(s);
    s = idle(); s.ei = 4'h7; s.cnd = 1'b1; run(s);
    // load-use together with ret in decode
    s = idle(); s.ei = 4'h5; s.edm = 4'h4; s.sa = 4'h4; s.di = 4'h9; run(s);
    // random hazard mix, no exceptions
    for (int i = 0; i < 30; i++) begin
      s = idle();
      s.di = 4'($urandom_range(0, 15)); s.ei = 4'($urandom_range(0, 15));
      s.mi = 4'($urandom_range(0, 15)); s.wi = 4'($urandom_range(0, 15));
      s.sa = 4'($urandom_range(0, 15)); s.sb = 4'($urandom_range(0, 15));
      s.edm = 4'($urandom_range(0, 15)); s.cnd = 1'($urandom_range(0, 1));
      run(s);
    end
    // wrap: 16 cycles after reset brings cyc_cnt back to 0
    s = idle(); s.rst = 1'b1; run(s);
    for (int i = 0; i < 16; i++) run(idle());
    chk("cyc_wrap", 32'(cyc_cnt), 32'd0);
    // exception drain: ADR in M, then in W
    s = idle(); s.ms = 3'd3; run(s);
    s = idle(); s.ms = 3'd3; run(s);                       // stays in DRAIN
    s = idle(); s.ws = 3'd3; run(s);
    chk("halted_after_drain", 32'(halted), 32'd1);
    // halted ignores hazards; counters frozen
    s = idle(); s.ei = 4'h7; s.cnd = 1'b0; s.mi = 4'h9; run(s);
    s = idle(); s.ei = 4'h5; s.edm = 4'h3; s.sa = 4'h3; s.ws = 3'd1; run(s);
    // reset while halted
    s = idle(); s.rst = 1'b1; s.ws = 3'd4; run(s);
    chk("state_after_reset", 32'(cpu_state), 32'd0);
    chk("cyc_after_reset", 32'(cyc_cnt), 32'd0);
    run(idle());
    // m_exc and w_exc together: RUN straight to HALTED
    s = idle(); s.ms = 3'd4; s.ws = 3'd2; run(s);
    chk("direct_halt", 32'(cpu_state), 32'd2);
    run(idle());
    // reset in the middle of DRAIN
    s = idle(); s.rst = 1'b1; run(s);
    s = idle(); s.ms = 3'd2; run(s);
    s = idle(); s.rst = 1'b1; s.ms = 3'd2; run(s);
    run(idle());
    run(idle());
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of every performance counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports D_icode, E_icode, M_icode, W_icode  input  4 each  icode held in each pipeline register.
REQ-005 SHALL have ports d_srcA, d_srcB  input  4 each  decode-stage source registers; 4'hF means none.
REQ-006 SHALL have port E_dstM  input  4  execute-stage memory destination register; 4'hF means none.
REQ-007 SHALL have port e_cnd  input  1  execute-stage condition result.
REQ-008 SHALL have ports m_stat, W_stat  input  3 each  status codes: AOK=1, HLT=2, ADR=3, INS=4.
REQ-009 SHALL have ports F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  output  1 each  pipeline register controls.
REQ-010 SHALL have port cpu_state  output  2  RUN=0, DRAIN=1, HALTED=2.
REQ-011 SHALL have port halted  output  1  high exactly when cpu_state==HALTED.
REQ-012 SHALL have ports cyc_cnt, stall_cnt, mispred_cnt, ret_cnt, retire_cnt  output  CNT_W each  performance counters.

Function
REQ-013 SHALL define load_use = (E_icode==5 or E_icode==4'hB) and E_dstM!=4'hF and (E_dstM==d_srcA or E_dstM==d_srcB).
REQ-014 SHALL define ret_haz = icode 9 present in any of D_icode, E_icode, M_icode.
REQ-015 SHALL define mispred = E_icode==7 and !e_cnd.
REQ-016 SHALL define m_exc = m_stat!=AOK; w_exc = W_stat!=AOK.
REQ-017 SHALL, in RUN and DRAIN, drive combinationally: F_stall = load_use|ret_haz; D_stall = load_use; D_bubble = mispred|(ret_haz&!load_use); E_bubble = mispred|load_use; M_bubble = m_exc|w_exc; W_stall = w_exc.
REQ-018 SHALL give load_use priority over ret_haz: simultaneous case stalls F and D, bubbles E, does not bubble D.
REQ-019 SHALL, in HALTED, drive F_stall, D_stall, W_stall = 1 and all bubbles = 0, ignoring all hazard inputs.
REQ-020 SHALL transition RUN->DRAIN on a clock edge where m_exc=1 and w_exc=0.
REQ-021 SHALL transition RUN or DRAIN->HALTED on a clock edge where w_exc=1; w_exc takes priority over m_exc.
REQ-022 SHALL hold DRAIN until w_exc; HALTED SHALL persist until reset.
REQ-023 SHALL increment cyc_cnt every non-reset cycle in RUN or DRAIN; frozen in HALTED.
REQ-024 SHALL increment stall_cnt on each RUN/DRAIN cycle with F_stall=1.
REQ-025 SHALL increment mispred_cnt on each RUN/DRAIN cycle with mispred=1.
REQ-026 SHALL increment ret_cnt on each RUN/DRAIN cycle with M_icode==9.
REQ-027 SHALL increment retire_cnt on each cycle with W_stat==AOK, W_icode!=1, state!=HALTED.
REQ-028 SHALL wrap all counters modulo 2^CNT_W without saturation or flag.
REQ-029 SHALL have counters updated one cycle after the qualifying event (registered); control outputs have zero latency.

Reset
REQ-030 SHALL, on a clock edge with reset=1, set cpu_state=RUN and all counters=0, regardless of current state (including mid-DRAIN or HALTED).
REQ-031 SHALL, while reset=1, drive D_bubble=E_bubble=M_bubble=1, F_stall=D_stall=W_stall=0, halted=0.

Verification
REQ-032 SHALL cover load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; stall_cnt+1 next cycle.
REQ-033 SHALL cover ret: D_icode=9 three cycles moving D->E->M -> F_stall=D_bubble=1 each cycle; ret_cnt=1, stall_cnt=3 afterwards.
REQ-034 SHALL cover mispredict: E_icode=7, e_cnd=0 -> D_bubble=E_bubble=1, F_stall=0; mispred_cnt+1.
REQ-035 SHALL cover exception drain: m_stat=ADR one cycle then W_stat=ADR -> M_bubble=1, cpu_state 0->1->2, halted=1, cyc_cnt frozen.
REQ-036 SHALL cover simultaneous events: load_use with D_icode=9 -> D_bubble=0; m_exc and w_exc together from RUN -> direct to HALTED.
REQ-037 SHALL cover counter wrap with CNT_W=4: 16 run cycles -> cyc_cnt returns to 0; reset while HALTED -> RUN, counters 0.
